window_filter_ctrl: RTL
=======================

# window_filter_ctrl

Scan/filter engine on the initiator side of the 3x3 sliding-window image memory. Walks every valid 3x3 window origin of a frame in raster order, issues a read, captures the nine window pixels returned by the memory, computes one filtered pixel, and writes it back to the filtered-image plane at the window centre. One window in flight at a time; read and write requests never overlap.

## Interface
- IMG_W, 256: frame width in pixels, 3..256
- IMG_H, 256: frame height in pixels, 3..256
- RD_LAT, 2: cycles from `rd` high to valid `sw_pixel_*`, >=1
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `start`  in  1  begin one frame; sampled only in IDLE
- `busy`  out  1  high from first READ through last WRITE
- `done`  out  1  one-cycle pulse after the last write of a frame
- `rd`  out  1  read request to memory, one-cycle pulse
- `addr_row_r`, `addr_col_r`  out  8 each  window origin (top-left)
- `sw_pixel_1`..`sw_pixel_9`  in  8 each  window pixels, row-major from origin
- `wr`  out  1  write request to memory, one-cycle pulse
- `addr_row_w`, `addr_col_w`  out  8 each  write address = origin row+1, col+1
- `cl_pixel`  out  8  filtered pixel

## Operation
- States: IDLE, READ, WAIT, CALC, WRITE.
- IDLE: `start`=1 at an edge -> origin (0,0), go READ. `start` outside IDLE ignored.
- READ (1 cycle): `rd`=1, read address = current origin. -> WAIT, wait counter = RD_LAT.
- WAIT (RD_LAT cycles): read address held. At end of last WAIT cycle, `sw_pixel_1..9` captured into internal window registers. -> CALC.
- CALC (1 cycle): filter result computed from window registers, registered into `cl_pixel`. -> WRITE.
- WRITE (1 cycle): `wr`=1, `addr_row_w/col_w` = origin+(1,1), `cl_pixel` valid. Then advance origin: col+1; if col==IMG_W-3, col=0, row+1. If origin was (IMG_H-3, IMG_W-3): -> IDLE, `done`=1 next cycle, `busy`=0. Else -> READ.
- Default filter (mean): 12-bit sum of nine pixels (max 2295); result = (sum*7282)>>16, equal to floor(sum/9) for all legal sums; 26-bit product, no saturation needed.
- Write addresses and `cl_pixel` hold their last value outside WRITE; `rd`/`wr` are 0 outside READ/WRITE.
- Border rows/columns (0, IMG_W-1, IMG_H-1) are never written.

## Timing
- Reset: `busy`,`done`,`rd`,`wr`=0; all address outputs and `cl_pixel`=0; state IDLE; window registers 0. Reset mid-frame aborts immediately, no further requests.
- `start` high at edge E -> `rd` high in cycle after E.
- Per window: 3+RD_LAT cycles (5 at default). `wr` asserted RD_LAT+2 cycles after `rd`; next `rd` in cycle after `wr`.
- `rd` and `wr` never high in the same cycle; `wr` followed immediately by `rd` is legal (memory registers both requests; write completes before next read takes effect).
- Frame: (IMG_W-2)*(IMG_H-2) writes; default 64516 writes, 322580 cycles from first `rd` to last `wr` inclusive.

## Configuration
- `WIN_MEDIAN_EN` defined: CALC produces the median of the nine pixels (19-compare-exchange sorting network, single registered stage); latency unchanged. Undefined: mean filter as above; no comparator network synthesised.

## Test plan
- Reset: assert `rst`=0 mid-frame -> all outputs 0 within the same cycle, no `rd`/`wr` after release until new `start`.
- IMG_W=IMG_H=4, memory model all 90, `start` pulse -> exactly 4 `wr` pulses at (1,1),(1,2),(2,1),(2,2), `cl_pixel`=90, `done` one cycle after 4th `wr`.
- Mean: window 1..9 -> 5; all 255 -> 255; eight 1s + one 0 -> 0; four 0s + five 255 -> 141.
- `WIN_MEDIAN_EN`: four 0s + five 255 -> 255; window 9,1,8,2,7,3,6,4,5 -> 5.
- Sequencing: `rd` pulses spaced 5 cycles, `wr` 4 cycles after each `rd`, never coincident; read address stable from READ through end of WAIT; `start` pulsed while `busy` -> ignored.
- Default 256x256 frame -> 64516 writes, last at (254,254), `busy` falls with `done`.

Source files
------------

// File: rtl/window_filter_ctrl.sv
// window_filter_ctrl: raster scan of every 3x3 window origin, one read/filter/write per window.
// Optional build macro WIN_MEDIAN_EN swaps the default mean filter for a 9-input median.
module window_filter_ctrl #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rd,
  output logic [7:0] addr_row_r,
  output logic [7:0] addr_col_r,
  input  logic [7:0] sw_pixel_1,
  input  logic [7:0] sw_pixel_2,
  input  logic [7:0] sw_pixel_3,
  input  logic [7:0] sw_pixel_4,
  input  logic [7:0] sw_pixel_5,
  input  logic [7:0] sw_pixel_6,
  input  logic [7:0] sw_pixel_7,
  input  logic [7:0] sw_pixel_8,
  input  logic [7:0] sw_pixel_9,
  output logic       wr,
  output logic [7:0] addr_row_w,
  output logic [7:0] addr_col_w,
  output logic [7:0] cl_pixel,
  output logic [2:0] state_dbg
);

  // Handshake: rd and wr are single-cycle strobes with no ready; the memory accepts
  // each one on the clock edge that ends the strobe cycle, and read data must be
  // valid RD_LAT cycles after rd is raised, held at least through that cycle.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    CALC  = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam int             WCW       = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [WCW-1:0] WAIT_INIT = WCW'(RD_LAT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(1);
  localparam logic [7:0]     COL_LAST  = 8'(IMG_W - 3);
  localparam logic [7:0]     ROW_LAST  = 8'(IMG_H - 3);

  state_t         state;
  state_t         state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic [7:0]     org_row;
  logic [7:0]     org_col;
  logic [7:0]     win [9];
  logic [7:0]     filt;
  logic           last_win;
  logic           wait_done;

  assign last_win  = (org_row == ROW_LAST) && (org_col == COL_LAST);
  assign wait_done = (wait_cnt == WAIT_LAST);

  assign rd         = (state == READ);
  assign wr         = (state == WRITE);
  assign busy       = (state != IDLE);
  assign addr_row_r = org_row;
  assign addr_col_r = org_col;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = CALC;
      CALC:    state_nxt = WRITE;
      WRITE:   state_nxt = last_win ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt   <= '0;
      org_row    <= '0;
      org_col    <= '0;
      addr_row_w <= '0;
      addr_col_w <= '0;
      cl_pixel   <= '0;
      done       <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      done <= (state == WRITE) && last_win;
      case (state)
        IDLE: begin
          if (start) begin
            org_row <= '0;
            org_col <= '0;
          end
        end
        READ: wait_cnt <= WAIT_INIT;
        WAIT: begin
          wait_cnt <= wait_cnt - WAIT_LAST;
          // Pixels are only guaranteed valid in the final WAIT cycle.
          if (wait_done) begin
            win[0] <= sw_pixel_1;
            win[1] <= sw_pixel_2;
            win[2] <= sw_pixel_3;
            win[3] <= sw_pixel_4;
            win[4] <= sw_pixel_5;
            win[5] <= sw_pixel_6;
            win[6] <= sw_pixel_7;
            win[7] <= sw_pixel_8;
            win[8] <= sw_pixel_9;
          end
        end
        CALC: begin
          cl_pixel   <= filt;
          addr_row_w <= org_row + 8'd1;
          addr_col_w <= org_col + 8'd1;
        end
        WRITE: begin
          if (org_col == COL_LAST) begin
            org_col <= '0;
            org_row <= org_row + 8'd1;
          end else begin
            org_col <= org_col + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WIN_MEDIAN_EN
  // Compare-exchange pairs: after each step the first index holds the smaller value;
  // after all 19 steps position 4 holds the median.
  localparam logic [3:0] CX_A [19] = '{4'd1, 4'd4, 4'd7, 4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd0,
                                       4'd5, 4'd4, 4'd3, 4'd1, 4'd2, 4'd4, 4'd4, 4'd6, 4'd4};
  localparam logic [3:0] CX_B [19] = '{4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8, 4'd3,
                                       4'd8, 4'd7, 4'd6, 4'd4, 4'd5, 4'd7, 4'd2, 4'd4, 4'd2};

  logic [7:0] med_v [9];
  logic [7:0] med_t;

  always_comb begin
    for (int i = 0; i < 9; i++) med_v[i] = win[i];
    med_t = '0;
    for (int k = 0; k < 19; k++) begin
      if (med_v[CX_A[k]] > med_v[CX_B[k]]) begin
        med_t           = med_v[CX_A[k]];
        med_v[CX_A[k]]  = med_v[CX_B[k]];
        med_v[CX_B[k]]  = med_t;
      end
    end
    filt = med_v[4];
  end
`else
  logic [11:0] sum9;
  logic [25:0] prod;

  // 7282/65536 approximates 1/9 closely enough to give floor(sum/9) up to 2295.
  always_comb begin
    sum9 = '0;
    for (int i = 0; i < 9; i++) sum9 = sum9 + {4'd0, win[i]};
    prod = {14'd0, sum9} * 26'd7282;
    filt = 8'(prod >> 16);
  end
`endif

endmodule
